// File: rtl/fetch_buffer.sv
// In-order instruction fetch queue: credit-limited request issue, response queue, redirect with response draining.
// Define FETCH_STALL_CNT_EN to add the saturating stall_count output.
module fetch_buffer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h8002_0000,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable_fetch,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic [1:0]            mem_access_size,
  input  logic                  mem_busy,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  insn_valid,
  output logic [DATA_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]           stall_count,
`endif
  input  logic                  decode_ready
);
  localparam int                    PW      = $clog2(DEPTH);
  localparam int                    CW      = PW + 1;
  localparam logic [CW:0]           DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_outst;
  logic [CW-1:0]         r_drop;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_qpc  [DEPTH];

  logic          w_credit;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_outst_next;

  // Credit counts queued plus in-flight words so every response always has a free slot.
  always_comb begin
    w_credit     = ({1'b0, r_count} + {1'b0, r_outst}) < DEPTH_C;
    mem_enable   = reset_n && enable_fetch && !redirect_valid && w_credit;
    w_accept     = mem_enable && !mem_busy;
    w_push       = mem_rvalid && (r_drop == '0) && !redirect_valid;
    w_pop        = insn_valid && decode_ready;
    w_outst_next = r_outst + CW'(w_accept) - CW'(mem_rvalid);
  end

  assign mem_addr        = r_pc;
  assign mem_rw          = 1'b1;
  assign mem_access_size = 2'b00;
  assign insn_valid      = (r_count != '0);
  assign insn            = r_data[r_rd_ptr];
  assign insn_pc         = r_qpc[r_rd_ptr];

  // Responses arrive in order, so r_resp_pc tracks the PC of the next non-dropped response.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pc      <= START_ADDR;
      r_resp_pc <= START_ADDR;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_outst   <= '0;
      r_drop    <= '0;
      r_data    <= '{default: '0};
      r_qpc     <= '{default: '0};
    end else if (redirect_valid) begin
      r_pc      <= redirect_pc;
      r_resp_pc <= redirect_pc;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_outst   <= w_outst_next;
      r_drop    <= w_outst_next;
    end else begin
      r_outst <= w_outst_next;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_accept) begin
        r_pc <= r_pc + STEP_C;
      end
      if (mem_rvalid && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_push) begin
        r_data[r_wr_ptr] <= mem_data_out;
        r_qpc[r_wr_ptr]  <= r_resp_pc;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
        r_resp_pc        <= r_resp_pc + STEP_C;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where decode holds off a valid head; redirects leave it alone.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stall_cnt <= 32'd0;
    end else if (insn_valid && !decode_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif
endmodule
